rotation_matrix_scheduler: RTL and testbench
============================================

# rotation_matrix_scheduler

Shares one external CORDIC sin/cos core between three rotation-matrix requesters (X, Y, Z axes). A round-robin arbiter picks the requester, and the block issues its angle to the core and waits for the result. It then assembles the matching 4x4 homogeneous rotation matrix in Q1.10.5 and presents it with an axis tag. It sits between the transform-setup logic and the matrix multiplier, and replaces one CORDIC per axis.

## Interface
- TIMEOUT, 64: maximum cycles to wait for the CORDIC result before aborting; minimum 2.
- CLK  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- req  in  3  request per axis, bit0 = X, bit1 = Y, bit2 = Z; level, held until granted.
- angleX, angleY, angleZ  in  16 each  signed angle in radians, Q1.2.13; must be stable while the matching req is high.
- grant  out  3  one-hot grant; pulses for exactly one cycle in ISSUE.
- cordic_tvalid  out  1  phase-valid to the core; high only in ISSUE.
- cordic_tdata  out  16  latched angle of the granted axis.
- cordic_out_tvalid  in  1  result valid from the core.
- cordic_out_tdata  in  32  {sin, cos}, each signed Q1.1.14.
- mtrx  out  256  registered matrix, row-major {m11..m14, m21..m44}, each element 16-bit Q1.10.5.
- mtrx_axis  out  2  axis of mtrx: 0 = X, 1 = Y, 2 = Z.
- mtrx_valid  out  1  one-cycle pulse when mtrx/mtrx_axis update.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on timeout.

## Operation
- FSM states:
  - IDLE: if req != 0, select an axis by round-robin, latch its angle and axis, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: assert cordic_tvalid and grant[axis] for one cycle. Clear the wait counter. Go to WAIT.
  - WAIT: when cordic_out_tvalid = 1, register the matrix and go to DONE.
    - Otherwise increment the counter.
    - When the counter reaches TIMEOUT-1 with no result, pulse err and go to IDLE. mtrx is unchanged and no mtrx_valid is issued.
  - DONE: pulse mtrx_valid. Go to IDLE.
- Round-robin arbitration:
  - The priority pointer resets to X.
  - After a grant to axis k, the highest priority moves to (k+1) mod 3.
  - The pointer is unchanged on timeout; the timed-out axis keeps its position.
- cordic_out_tvalid outside WAIT is ignored.
- Only one transaction is outstanding at a time.
- Arithmetic:
  - Let s = sin, c = cos, and ns = -sin, with 16-bit two's-complement wrap.
  - Each element is the value arithmetically shifted right by 9 (>>>9), giving Q1.10.5.
  - ONE = 16'h0020; Z0 = 16'h0000.
- Matrix by axis:
  - X: [ONE Z0 Z0 Z0; Z0 c ns Z0; Z0 s c Z0; Z0 Z0 Z0 ONE]
  - Y: [c Z0 s Z0; Z0 ONE Z0 Z0; ns Z0 c Z0; Z0 Z0 Z0 ONE]
  - Z: [c ns Z0 Z0; s c Z0 Z0; Z0 Z0 ONE Z0; Z0 Z0 Z0 ONE]
- Reset (asynchronous, active-low):
  - FSM goes to IDLE; pointer goes to X.
  - grant, cordic_tvalid, cordic_tdata, mtrx, mtrx_axis, mtrx_valid, busy, err and the counter all clear to 0.
- Reset mid-transaction abandons the transaction. A late CORDIC result that arrives after reset is ignored, because the FSM is in IDLE.

## Timing
- req high at edge t (FSM in IDLE) gives:
  - ISSUE (grant, cordic_tvalid) during cycle t+1.
  - WAIT from t+2.
- Core latency L (tvalid seen L cycles after ISSUE) gives mtrx_valid L+1 cycles after ISSUE. Total from IDLE sample: L+2 cycles.
- Back-to-back requests: the next IDLE decision is made in the cycle after DONE, so at least L+3 cycles between grants.
- req dropped before grant: no transaction for that axis. The angle was latched in IDLE, so req may drop after the grant.
- Simultaneous requests: exactly one grant per transaction, in rotation order.
- mtrx and mtrx_axis hold their values between mtrx_valid pulses.

## Test plan
- Single Z request: angleZ = 0, core returns sin = 0, cos = 16'h4000 -> grant = 3'b100; mtrx_axis = 2; m11 = m22 = m33 = m44 = 16'h0020; all other elements 0.
- X request: core returns sin = 16'h2000, cos = 16'h376D -> m22 = m33 = 16'h001B, m32 = 16'h0010, m23 = 16'hFFF0, m11 = 16'h0020.
- Y sign placement: sin = 16'h2000 -> m13 = 16'h0010 and m31 = 16'hFFF0.
- req = 3'b111 held for three transactions from reset -> grants in order X, Y, Z. Then req = 3'b101 -> X is granted before Z.
- Core never responds, TIMEOUT = 8 -> err pulses once 8 cycles after ISSUE; mtrx_valid stays 0; busy falls; the next request proceeds normally.
- Reset asserted in WAIT, then a late cordic_out_tvalid -> all outputs are 0 and no mtrx_valid is issued. Stray tvalid in IDLE is also ignored.

Source files
------------

// File: rtl/rotation_matrix_scheduler.sv
// Purpose : shares one CORDIC sin/cos core between X/Y/Z rotation requesters
//           (round-robin) and builds the 4x4 homogeneous rotation matrix, Q1.10.5.
// Latency : grant one cycle after req is seen in IDLE; mtrx_valid L+1 cycles after
//           the grant, where L is the core latency.
// Backpressure: one transaction at a time; req is held until granted; a missing
//           result aborts after TIMEOUT cycles with an err pulse.
// Ports   : CLK/rst (async active-low), req + angleX/Y/Z from setup logic,
//           grant, cordic_* handshake to the core, mtrx/mtrx_axis/mtrx_valid to the
//           multiplier, busy and err status.
module rotation_matrix_scheduler #(
  parameter int TIMEOUT = 64
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic [2:0]   req,
  input  logic [15:0]  angleX,
  input  logic [15:0]  angleY,
  input  logic [15:0]  angleZ,
  output logic [2:0]   grant,
  output logic         cordic_tvalid,
  output logic [15:0]  cordic_tdata,
  input  logic         cordic_out_tvalid,
  input  logic [31:0]  cordic_out_tdata,
  output logic [255:0] mtrx,
  output logic [1:0]   mtrx_axis,
  output logic         mtrx_valid,
  output logic         busy,
  output logic         err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [15:0] ONE = 16'h0020;
  localparam logic [15:0] Z0  = 16'h0000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    ptr;
  logic [1:0]    axis;
  logic [CW-1:0] cnt;

  logic [2:0]    rot;
  logic [1:0]    off;
  logic [2:0]    sum;
  logic [1:0]    pick;
  logic          pick_vld;
  logic [15:0]   pick_angle;

  // Rotate req so the current highest-priority axis lands in bit 0, take the
  // first set bit, then rotate the offset back into an absolute axis number.
  always_comb begin
    rot = req;
    case (ptr)
      2'd1:    rot = {req[0], req[2], req[1]};
      2'd2:    rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase
    off = rot[0] ? 2'd0 : (rot[1] ? 2'd1 : 2'd2);
    sum = {1'b0, ptr} + {1'b0, off};
    pick = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    pick_vld = |req;
  end

  always_comb begin
    case (pick)
      2'd0:    pick_angle = angleX;
      2'd1:    pick_angle = angleY;
      default: pick_angle = angleZ;
    endcase
  end

  // ns is formed by negating the raw Q1.1.14 sine before the shift, so it is
  // not simply the negation of the shifted s (floor rounding differs).
  function automatic logic [255:0] build_mtrx(input logic [1:0] ax, input logic [31:0] sc);
    logic [15:0] s, c, ns, neg;
    s   = $signed(sc[31:16]) >>> 9;
    c   = $signed(sc[15:0]) >>> 9;
    neg = ~sc[31:16] + 16'd1;
    ns  = $signed(neg) >>> 9;
    case (ax)
      2'd0:    build_mtrx = {ONE, Z0, Z0, Z0,  Z0, c, ns, Z0,  Z0, s, c, Z0,  Z0, Z0, Z0, ONE};
      2'd1:    build_mtrx = {c, Z0, s, Z0,  Z0, ONE, Z0, Z0,  ns, Z0, c, Z0,  Z0, Z0, Z0, ONE};
      default: build_mtrx = {c, ns, Z0, Z0,  s, c, Z0, Z0,  Z0, Z0, ONE, Z0,  Z0, Z0, Z0, ONE};
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    err       = 1'b0;
    case (state)
      IDLE:  if (pick_vld) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (cordic_out_tvalid) begin
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign grant         = (state == ISSUE) ? (3'b001 << axis) : 3'b000;
  assign cordic_tvalid = (state == ISSUE);
  assign mtrx_valid    = (state == DONE);
  assign busy          = (state != IDLE);

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= 2'd0;
      axis         <= 2'd0;
      cnt          <= '0;
      cordic_tdata <= 16'd0;
      mtrx         <= 256'd0;
      mtrx_axis    <= 2'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            axis         <= pick;
            cordic_tdata <= pick_angle;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (cordic_out_tvalid) begin
            mtrx      <= build_mtrx(axis, cordic_out_tdata);
            mtrx_axis <= axis;
            // Pointer advances only on a completed transaction; a timed-out
            // axis keeps its priority slot.
            ptr       <= (axis == 2'd2) ? 2'd0 : axis + 2'd1;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rotation_matrix_scheduler.sv
module tb_rotation_matrix_scheduler;
  localparam int TO = 8;

  logic         CLK = 1'b0;
  logic         rst = 1'b0;
  logic [2:0]   req = 3'b000;
  logic [15:0]  angleX = 16'd0, angleY = 16'd0, angleZ = 16'd0;
  logic         cordic_out_tvalid = 1'b0;
  logic [31:0]  cordic_out_tdata = 32'd0;
  logic [2:0]   grant;
  logic         cordic_tvalid;
  logic [15:0]  cordic_tdata;
  logic [255:0] mtrx;
  logic [1:0]   mtrx_axis;
  logic         mtrx_valid, busy, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ptr_m = 0;

  rotation_matrix_scheduler #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .rst(rst), .req(req),
    .angleX(angleX), .angleY(angleY), .angleZ(angleZ),
    .grant(grant), .cordic_tvalid(cordic_tvalid), .cordic_tdata(cordic_tdata),
    .cordic_out_tvalid(cordic_out_tvalid), .cordic_out_tdata(cordic_out_tdata),
    .mtrx(mtrx), .mtrx_axis(mtrx_axis), .mtrx_valid(mtrx_valid),
    .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [1:0] pick_model(input logic [2:0] r, input int p);
    for (int i = 0; i < 3; i++)
      if (r[(p + i) % 3]) return 2'((p + i) % 3);
    return 2'd3;
  endfunction

  // floor(v / 512) as a 16-bit two's-complement value
  function automatic logic [15:0] q_shift(input int v);
    int f;
    f = v / 512;
    if ((v % 512) != 0 && v < 0) f = f - 1;
    return 16'(f);
  endfunction

  // Rotation about axis a acts on the other two axes p=(a+1)%3, q=(a+2)%3:
  // [p][p]=c, [p][q]=-s, [q][p]=s, [q][q]=c; everything else is identity.
  function automatic logic [255:0] exp_mtrx(input logic [1:0] ax, input logic [15:0] sn, input logic [15:0] cs);
    logic [15:0] e [4][4];
    logic [255:0] r;
    int sv, cv, nv, p, q;
    sv = int'($signed(sn));
    cv = int'($signed(cs));
    nv = -sv;
    if (nv == 32768) nv = -32768;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        e[i][j] = (i == j) ? 16'h0020 : 16'h0000;
    p = (int'(ax) + 1) % 3;
    q = (int'(ax) + 2) % 3;
    e[p][p] = q_shift(cv);
    e[q][q] = q_shift(cv);
    e[p][q] = q_shift(nv);
    e[q][p] = q_shift(sv);
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[255 - 16*(4*i + j) -: 16] = e[i][j];
    return r;
  endfunction

  function automatic logic [15:0] elem(input logic [255:0] m, input int i, input int j);
    return m[255 - 16*(4*(i-1) + (j-1)) -: 16];
  endfunction

  function automatic logic [15:0] ang_of(input logic [1:0] ax);
    case (ax)
      2'd0:    return angleX;
      2'd1:    return angleY;
      default: return angleZ;
    endcase
  endfunction

  // ---------------- stimulus driver (no checking) ----------------
  task automatic run_txn(input logic [2:0] r, input int lat, input logic [31:0] sc, input bit drop,
                         output logic [2:0] g, output logic [15:0] td, output logic tv,
                         output logic [255:0] m, output logic [1:0] tag,
                         output int lat_obs, output int t_g, output bit ok);
    ok = 0; g = '0; td = '0; tv = 1'b0; m = '0; tag = '0; lat_obs = -1; t_g = -1;
    req = r;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (grant != 3'b000) begin ok = 1; break; end
    end
    if (!ok) return;
    g = grant; td = cordic_tdata; tv = cordic_tvalid; t_g = cyc;
    if (drop) req = 3'b000;
    repeat (lat) @(negedge CLK);
    cordic_out_tvalid = 1'b1;
    cordic_out_tdata  = sc;
    ok = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      cordic_out_tvalid = 1'b0;
      if (mtrx_valid) begin
        ok = 1; lat_obs = lat + i; m = mtrx; tag = mtrx_axis;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({grant, cordic_tvalid, cordic_tdata, mtrx_axis, mtrx_valid, busy, err} !== 25'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h expected 0", {grant, cordic_tvalid, cordic_tdata, mtrx_axis, mtrx_valid, busy, err});
    end
    checks++;
    if (mtrx !== 256'd0) begin errors++; $display("FAIL reset_mtrx: got %h expected 0", mtrx); end
    rst = 1'b1;
    @(negedge CLK);
    checks++;
    if ({grant, busy, mtrx_valid, err} !== 6'd0) begin
      errors++; $display("FAIL reset_idle: got %b expected 0", {grant, busy, mtrx_valid, err});
    end
    ptr_m = 0;
  endtask

  task automatic test_single_z;
    logic [2:0] g; logic [15:0] td; logic tv; logic [255:0] m; logic [1:0] tag; int lo, tg; bit ok;
    angleX = 16'($urandom); angleY = 16'($urandom); angleZ = 16'h0000;
    run_txn(3'b100, 2, {16'h0000, 16'h4000}, 1, g, td, tv, m, tag, lo, tg, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL z_done: got no completion expected mtrx_valid"); end
    checks++;
    if (g !== 3'b100) begin errors++; $display("FAIL z_grant: got %b expected 100", g); end
    checks++;
    if (tv !== 1'b1 || td !== 16'h0000) begin errors++; $display("FAIL z_issue: got tvalid=%b tdata=%h expected 1/0000", tv, td); end
    checks++;
    if (tag !== 2'd2) begin errors++; $display("FAIL z_axis: got %0d expected 2", tag); end
    checks++;
    if (m !== 256'h0020_0000_0000_0000_0000_0020_0000_0000_0000_0000_0020_0000_0000_0000_0000_0020) begin
      errors++; $display("FAIL z_identity: got %h", m);
    end
    checks++;
    if (m !== exp_mtrx(2'd2, 16'h0000, 16'h4000)) begin errors++; $display("FAIL z_model: got %h expected %h", m, exp_mtrx(2'd2, 16'h0000, 16'h4000)); end
    checks++;
    if (lo !== 3) begin errors++; $display("FAIL z_latency: got %0d expected 3", lo); end
    ptr_m = 0;
    @(negedge CLK);
    checks++;
    if (mtrx_valid !== 1'b0 || mtrx !== m) begin errors++; $display("FAIL z_hold: got valid=%b mtrx=%h", mtrx_valid, mtrx); end
  endtask

  task automatic test_x_vector;
    logic [2:0] g; logic [15:0] td; logic tv; logic [255:0] m; logic [1:0] tag; int lo, tg; bit ok;
    angleX = 16'($urandom);
    run_txn(3'b001, 3, {16'h2000, 16'h376D}, 1, g, td, tv, m, tag, lo, tg, ok);
    checks++;
    if (!ok || g !== 3'b001 || td !== angleX || tag !== 2'd0) begin
      errors++; $display("FAIL x_txn: got ok=%0d grant=%b tdata=%h axis=%0d expected 1/001/%h/0", ok, g, td, tag, angleX);
    end
    checks++;
    if (elem(m,2,2) !== 16'h001B || elem(m,3,3) !== 16'h001B) begin
      errors++; $display("FAIL x_cos: got m22=%h m33=%h expected 001B", elem(m,2,2), elem(m,3,3));
    end
    checks++;
    if (elem(m,3,2) !== 16'h0010 || elem(m,2,3) !== 16'hFFF0 || elem(m,1,1) !== 16'h0020) begin
      errors++; $display("FAIL x_sin: got m32=%h m23=%h m11=%h expected 0010/FFF0/0020", elem(m,3,2), elem(m,2,3), elem(m,1,1));
    end
    checks++;
    if (m !== exp_mtrx(2'd0, 16'h2000, 16'h376D)) begin errors++; $display("FAIL x_model: got %h expected %h", m, exp_mtrx(2'd0, 16'h2000, 16'h376D)); end
    ptr_m = 1;
  endtask

  task automatic test_y_sign;
    logic [2:0] g; logic [15:0] td; logic tv; logic [255:0] m; logic [1:0] tag; int lo, tg; bit ok;
    logic [15:0] cs;
    cs = 16'($urandom);
    angleY = 16'($urandom);
    run_txn(3'b010, 1, {16'h2000, cs}, 1, g, td, tv, m, tag, lo, tg, ok);
    checks++;
    if (!ok || g !== 3'b010 || tag !== 2'd1 || lo !== 2) begin
      errors++; $display("FAIL y_txn: got ok=%0d grant=%b axis=%0d lat=%0d expected 1/010/1/2", ok, g, tag, lo);
    end
    checks++;
    if (elem(m,1,3) !== 16'h0010 || elem(m,3,1) !== 16'hFFF0) begin
      errors++; $display("FAIL y_sign: got m13=%h m31=%h expected 0010/FFF0", elem(m,1,3), elem(m,3,1));
    end
    checks++;
    if (m !== exp_mtrx(2'd1, 16'h2000, cs)) begin errors++; $display("FAIL y_model: got %h expected %h", m, exp_mtrx(2'd1, 16'h2000, cs)); end
    ptr_m = 2;
  endtask

  task automatic test_round_robin;
    logic [2:0] g; logic [15:0] td; logic tv; logic [255:0] m; logic [1:0] tag; int lo, tg; bit ok;
    logic [2:0] order [5];
    logic [2:0] reqs [5];
    logic [1:0] ea;
    int prev_tg, prev_lat, lat;
    logic [31:0] sc;
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001; order[4] = 3'b100;
    reqs[0] = 3'b111; reqs[1] = 3'b111; reqs[2] = 3'b111; reqs[3] = 3'b101; reqs[4] = 3'b101;
    rst = 1'b0;
    repeat (2) @(negedge CLK);
    rst = 1'b1;
    ptr_m = 0;
    angleX = 16'($urandom); angleY = 16'($urandom); angleZ = 16'($urandom);
    prev_tg = -1; prev_lat = 0;
    for (int k = 0; k < 5; k++) begin
      lat = $urandom_range(1, 5);
      sc  = $urandom;
      ea  = pick_model(reqs[k], ptr_m);
      run_txn(reqs[k], lat, sc, 0, g, td, tv, m, tag, lo, tg, ok);
      checks++;
      if (!ok || g !== order[k] || g !== (3'b001 << ea)) begin
        errors++; $display("FAIL rr_grant%0d: got ok=%0d grant=%b expected %b", k, ok, g, order[k]);
      end
      checks++;
      if (m !== exp_mtrx(ea, sc[31:16], sc[15:0]) || tag !== ea || td !== ang_of(ea)) begin
        errors++; $display("FAIL rr_data%0d: got axis=%0d tdata=%h mtrx=%h", k, tag, td, m);
      end
      if (prev_tg >= 0) begin
        checks++;
        if (tg - prev_tg !== prev_lat + 3) begin
          errors++; $display("FAIL rr_gap%0d: got %0d cycles expected %0d", k, tg - prev_tg, prev_lat + 3);
        end
      end
      prev_tg = tg; prev_lat = lat;
      ptr_m = (int'(ea) + 1) % 3;
    end
    req = 3'b000;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_timeout;
    logic [2:0] g; logic [15:0] td; logic tv; logic [255:0] m; logic [1:0] tag; int lo, tg; bit ok;
    logic [255:0] saved;
    int first_k, n_err, n_vld;
    logic busy_after;
    bit got;
    saved = mtrx;
    got = 0;
    req = 3'b001;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (grant != 3'b000) begin got = 1; break; end
    end
    req = 3'b000;
    checks++;
    if (!got || grant !== 3'b001) begin errors++; $display("FAIL to_grant: got %b expected 001", grant); end
    first_k = -1; n_err = 0; n_vld = 0; busy_after = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (err) begin n_err++; if (first_k < 0) first_k = k; end
      if (mtrx_valid) n_vld++;
      if (k == TO + 1) busy_after = busy;
    end
    checks++;
    if (first_k !== TO || n_err !== 1) begin errors++; $display("FAIL to_err: got first=%0d count=%0d expected %0d/1", first_k, n_err, TO); end
    checks++;
    if (n_vld !== 0 || mtrx !== saved) begin errors++; $display("FAIL to_quiet: got valids=%0d mtrx=%h expected 0/%h", n_vld, mtrx, saved); end
    checks++;
    if (busy_after !== 1'b0) begin errors++; $display("FAIL to_busy: got %b expected 0", busy_after); end
    // pointer must not have moved: X still wins over Y
    angleX = 16'($urandom); angleY = 16'($urandom);
    run_txn(3'b011, 2, 32'h1234_5678, 1, g, td, tv, m, tag, lo, tg, ok);
    checks++;
    if (!ok || g !== 3'b001 || g !== (3'b001 << pick_model(3'b011, ptr_m)) || m !== exp_mtrx(2'd0, 16'h1234, 16'h5678)) begin
      errors++; $display("FAIL to_recover: got ok=%0d grant=%b mtrx=%h expected grant 001", ok, g, m);
    end
    ptr_m = 1;
  endtask

  task automatic test_reset_mid;
    bit got;
    int bad;
    got = 0;
    req = 3'b010;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (grant != 3'b000) begin got = 1; break; end
    end
    req = 3'b000;
    checks++;
    if (!got || grant !== (3'b001 << pick_model(3'b010, ptr_m))) begin errors++; $display("FAIL rm_grant: got %b expected 010", grant); end
    repeat (2) @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    checks++;
    if ({grant, cordic_tvalid, cordic_tdata, mtrx_axis, mtrx_valid, busy, err} !== 25'd0 || mtrx !== 256'd0) begin
      errors++; $display("FAIL rm_reset: got ctrl=%h mtrx=%h expected 0", {grant, cordic_tvalid, cordic_tdata, mtrx_axis, mtrx_valid, busy, err}, mtrx);
    end
    cordic_out_tvalid = 1'b1;
    cordic_out_tdata  = $urandom;
    @(negedge CLK);
    rst = 1'b1;
    ptr_m = 0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (mtrx_valid || busy || grant != 3'b000 || mtrx != 256'd0 || err) bad++;
    end
    cordic_out_tvalid = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rm_late: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_random;
    logic [2:0] g; logic [15:0] td; logic tv; logic [255:0] m; logic [1:0] tag; int lo, tg; bit ok;
    logic [2:0] r; logic [1:0] ea; logic [31:0] sc; int lat; int bad;
    bad = 0;
    for (int n = 0; n < 24; n++) begin
      angleX = 16'($urandom); angleY = 16'($urandom); angleZ = 16'($urandom);
      r   = 3'($urandom_range(1, 7));
      lat = $urandom_range(1, 5);
      sc  = $urandom;
      ea  = pick_model(r, ptr_m);
      run_txn(r, lat, sc, 1, g, td, tv, m, tag, lo, tg, ok);
      checks++;
      if (!ok || g !== (3'b001 << ea) || td !== ang_of(ea) || tag !== ea || lo !== lat + 1
          || m !== exp_mtrx(ea, sc[31:16], sc[15:0])) begin
        errors++;
        $display("FAIL rand%0d: got ok=%0d grant=%b tdata=%h axis=%0d lat=%0d expected grant=%b tdata=%h axis=%0d lat=%0d",
                 n, ok, g, td, tag, lo, 3'b001 << ea, ang_of(ea), ea, lat + 1);
      end
      ptr_m = (int'(ea) + 1) % 3;
      @(negedge CLK);
      if (mtrx_valid || mtrx !== m) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rand_hold: got %0d bad cycles expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single_z();
    test_x_vector();
    test_y_sign();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
